// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Purpose  : Parametrised multi-port integer register file with hardwired-zero
//            register 0, optional write-to-read bypass and a per-register
//            pending-write scoreboard for issue-stage hazard detection.
// Ports    :
//   clk       - clock
//   reset     - synchronous active-high reset (also forces read outputs to 0)
//   rd_addr   - NRP read addresses, port p at [p*AW +: AW]
//   rd_en     - per-port read enable
//   rd_data   - NRP read data words, port p at [p*XLEN +: XLEN]
//   rd_busy   - pending-write flag of the addressed register, per port
//   wr_addr   - NWP write addresses
//   wr_en     - per-port write enable
//   wr_data   - NWP write data words
//   wr_clr    - clear scoreboard bit of wr_addr (only with wr_en)
//   iss_en    - mark iss_addr as having a pending write
//   iss_addr  - destination register being issued
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int NRP    = 2,
    parameter  int NWP    = 1,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRP*AW-1:0]    rd_addr,
    input  logic [NRP-1:0]       rd_en,
    output logic [NRP*XLEN-1:0]  rd_data,
    output logic [NRP-1:0]       rd_busy,
    input  logic [NWP*AW-1:0]    wr_addr,
    input  logic [NWP-1:0]       wr_en,
    input  logic [NWP*XLEN-1:0]  wr_data,
    input  logic [NWP-1:0]       wr_clr,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr
);

    // Entry 0 is reset to zero and never written, so it collapses to a
    // constant; reads of address 0 are additionally masked at the output.
    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pend;
    logic [NREGS-1:0] w_pend_next;

    // ------------------------------------------------------------------------
    // Storage: ascending port loop so the highest-index writer of an address
    // takes effect (last non-blocking assignment wins).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWP; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] != '0)) begin
                    r_regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard: clears first, then the issue set, so a new producer issued
    // in the same cycle as the old one's writeback keeps the register busy.
    // ------------------------------------------------------------------------
    always_comb begin
        w_pend_next = r_pend;
        for (int w = 0; w < NWP; w++) begin
            if (wr_en[w] && wr_clr[w]) begin
                w_pend_next[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (iss_en) begin
            w_pend_next[iss_addr] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports: combinational. Bypass picks the highest-index matching
    // writer; a same-cycle clear hides the busy flag immediately, whereas a
    // same-cycle issue only shows up once it is registered.
    // ------------------------------------------------------------------------
    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   w_raddr;
        logic [XLEN-1:0] w_data;
        logic            w_clr_hit;
        logic            w_valid;

        assign w_raddr = rd_addr[p*AW +: AW];
        assign w_valid = !reset && rd_en[p] && (w_raddr != '0);

        always_comb begin
            w_data    = r_regs[w_raddr];
            w_clr_hit = 1'b0;
            for (int w = 0; w < NWP; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == w_raddr)) begin
                    if (BYPASS != 0) begin
                        w_data = wr_data[w*XLEN +: XLEN];
                    end
                    if (wr_clr[w]) begin
                        w_clr_hit = 1'b1;
                    end
                end
            end
        end

        assign rd_data[p*XLEN +: XLEN] = w_valid ? w_data : '0;
        assign rd_busy[p]              = w_valid && r_pend[w_raddr] && !w_clr_hit;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Purpose  : Scoreboard bench for reg_file_mp. Two instances (bypass on/off)
//            share stimulus; a driver pushes the reference model's expected
//            read-port values into a queue and a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRP   = 2;
    localparam int NWP   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NRP*AW-1:0]   rd_addr = '0;
    logic [NRP-1:0]      rd_en = '0;
    logic [NWP*AW-1:0]   wr_addr = '0;
    logic [NWP-1:0]      wr_en = '0;
    logic [NWP*XLEN-1:0] wr_data = '0;
    logic [NWP-1:0]      wr_clr = '0;
    logic                iss_en = 1'b0;
    logic [AW-1:0]       iss_addr = '0;

    logic [NRP*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NRP-1:0]      rd_busy_b, rd_busy_n;

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP), .BYPASS(1)) u_dut_byp (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_data(rd_data_b), .rd_busy(rd_busy_b), .wr_addr(wr_addr),
        .wr_en(wr_en), .wr_data(wr_data), .wr_clr(wr_clr),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP), .BYPASS(0)) u_dut_nbp (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_data(rd_data_n), .rd_busy(rd_busy_n), .wr_addr(wr_addr),
        .wr_en(wr_en), .wr_data(wr_data), .wr_clr(wr_clr),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    typedef struct {
        logic [1:0][31:0] d_byp;
        logic [1:0][31:0] d_nbp;
        logic [1:0]       busy;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    // Architectural reference state
    logic [31:0] m_regs [NREGS];
    bit          m_pend [NREGS];

    // One cycle of stimulus: drive at negedge, record what the read ports
    // must show this cycle, then advance the model past the coming posedge.
    task automatic drive(input logic rst, input logic [1:0] ren,
                         input logic [1:0][4:0] ra,
                         input logic [1:0] wen, input logic [1:0][4:0] wa,
                         input logic [1:0][31:0] wd, input logic [1:0] wclr,
                         input logic ien, input logic [4:0] ia);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        rd_en    = ren;
        rd_addr  = {ra[1], ra[0]};
        wr_en    = wen;
        wr_addr  = {wa[1], wa[0]};
        wr_data  = {wd[1], wd[0]};
        wr_clr   = wclr;
        iss_en   = ien;
        iss_addr = ia;

        for (int p = 0; p < 2; p++) begin
            e.d_byp[p] = '0;
            e.d_nbp[p] = '0;
            e.busy[p]  = 1'b0;
            if (!rst && ren[p] && ra[p] != 0) begin
                e.d_nbp[p] = m_regs[ra[p]];
                e.d_byp[p] = m_regs[ra[p]];
                e.busy[p]  = m_pend[ra[p]];
                for (int w = 0; w < 2; w++) begin
                    if (wen[w] && wa[w] == ra[p]) begin
                        e.d_byp[p] = wd[w];
                        if (wclr[w]) e.busy[p] = 1'b0;
                    end
                end
            end
        end
        q.push_back(e);

        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            for (int w = 0; w < 2; w++)
                if (wen[w] && wa[w] != 0) m_regs[wa[w]] = wd[w];
            for (int w = 0; w < 2; w++)
                if (wen[w] && wclr[w]) m_pend[wa[w]] = 1'b0;
            if (ien && ia != 0) m_pend[ia] = 1'b1;
        end
    endtask

    // Shorthand: read-only cycle
    task automatic rd(input logic [1:0] ren, input logic [4:0] a0, input logic [4:0] a1);
        drive(1'b0, ren, {a1, a0}, 2'b00, '0, '0, 2'b00, 1'b0, 5'd0);
    endtask

    // Monitor: sample mid-low-phase, compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int p = 0; p < 2; p++) begin
                    checks++;
                    if (rd_data_b[p*32 +: 32] !== e.d_byp[p]) begin
                        errors++;
                        $display("FAIL byp_data p%0d t=%0t: got %h want %h", p, $time, rd_data_b[p*32 +: 32], e.d_byp[p]);
                    end
                    checks++;
                    if (rd_data_n[p*32 +: 32] !== e.d_nbp[p]) begin
                        errors++;
                        $display("FAIL nbp_data p%0d t=%0t: got %h want %h", p, $time, rd_data_n[p*32 +: 32], e.d_nbp[p]);
                    end
                    checks++;
                    if (rd_busy_b[p] !== e.busy[p]) begin
                        errors++;
                        $display("FAIL byp_busy p%0d t=%0t: got %b want %b", p, $time, rd_busy_b[p], e.busy[p]);
                    end
                    checks++;
                    if (rd_busy_n[p] !== e.busy[p]) begin
                        errors++;
                        $display("FAIL nbp_busy p%0d t=%0t: got %b want %b", p, $time, rd_busy_n[p], e.busy[p]);
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end

        // Reset, then preload x5 and confirm reset clears it
        drive(1'b1, 2'b11, {5'd5, 5'd0}, 2'b00, '0, '0, 2'b00, 1'b0, 5'd0);
        drive(1'b0, 2'b00, '0, 2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 2'b00, 1'b1, 5'd5);
        rd(2'b11, 5'd5, 5'd5);
        drive(1'b1, 2'b11, {5'd5, 5'd5}, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h00001234}, 2'b00, 1'b0, 5'd0);
        rd(2'b11, 5'd5, 5'd5);

        // x0 is hardwired zero and never busy
        drive(1'b0, 2'b11, '0, 2'b01, '0, {32'h0, 32'hFFFFFFFF}, 2'b00, 1'b1, 5'd0);
        rd(2'b11, 5'd0, 5'd0);

        // Same-cycle write/read of x7: bypass vs stored value
        drive(1'b0, 2'b10, {5'd7, 5'd0}, 2'b01, {5'd0, 5'd7}, {32'h0, 32'hA5A5A5A5}, 2'b00, 1'b0, 5'd0);
        rd(2'b11, 5'd7, 5'd7);

        // Both write ports hit x3: higher port wins
        drive(1'b0, 2'b11, {5'd3, 5'd3}, 2'b11, {5'd3, 5'd3}, {32'h22, 32'h11}, 2'b00, 1'b0, 5'd0);
        rd(2'b11, 5'd3, 5'd3);

        // Scoreboard on x9: issue, clear (combinational), issue+clear together
        drive(1'b0, 2'b01, {5'd0, 5'd9}, 2'b00, '0, '0, 2'b00, 1'b1, 5'd9);
        rd(2'b11, 5'd9, 5'd9);
        drive(1'b0, 2'b11, {5'd9, 5'd9}, 2'b01, {5'd0, 5'd9}, {32'h0, 32'h99}, 2'b01, 1'b0, 5'd0);
        rd(2'b11, 5'd9, 5'd9);
        drive(1'b0, 2'b00, '0, 2'b00, '0, '0, 2'b00, 1'b1, 5'd9);
        drive(1'b0, 2'b11, {5'd9, 5'd9}, 2'b10, {5'd9, 5'd0}, {32'h9A, 32'h0}, 2'b10, 1'b1, 5'd9);
        rd(2'b11, 5'd9, 5'd9);

        // Disabled read port on a busy register holding 0x55
        drive(1'b0, 2'b00, '0, 2'b01, {5'd0, 5'd4}, {32'h0, 32'h55}, 2'b00, 1'b1, 5'd4);
        rd(2'b10, 5'd4, 5'd4);

        // Randomized traffic over a small address window to force collisions
        for (int n = 0; n < 400; n++) begin
            logic [1:0][4:0]  ra, wa;
            logic [1:0][31:0] wd;
            ra[0] = 5'($urandom_range(0, 7));
            ra[1] = 5'($urandom_range(0, 7));
            wa[0] = 5'($urandom_range(0, 7));
            wa[1] = 5'($urandom_range(0, 7));
            wd[0] = $urandom;
            wd[1] = $urandom;
            drive(($urandom_range(0, 49) == 0), 2'($urandom), ra, 2'($urandom), wa, wd,
                  2'($urandom), 1'($urandom), 5'($urandom_range(0, 7)));
        end

        // Let the monitor drain the queue within a bounded number of cycles
        repeat (3) @(negedge clk);
        #5;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
